// File: rtl/vram_stream_writer.sv
// Converts buffered text/fill commands into VRAM register-port write beats.
// Keeps a shadow of the responder's auto-incrementing VRAM address.
module vram_stream_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  input  logic        abort,
  output logic        bus_req,
  output logic [1:0]  bus_reg,
  output logic [7:0]  bus_data,
  input  logic        bus_ack,
  output logic        busy,
  output logic [15:0] shadow_addr
);

  localparam int unsigned ENT_W = 18;
  localparam int unsigned CNT_W = FIFO_AW + 1;
  localparam int unsigned REM_W = 9;

  localparam logic [1:0] OP_SET_ADDR = 2'd0;
  localparam logic [1:0] OP_SET_ATTR = 2'd1;
  localparam logic [1:0] OP_PUT      = 2'd2;
  localparam logic [1:0] OP_FILL     = 2'd3;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_ATTR    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               rdy_q;

  state_t             state;
  logic [1:0]         cur_op;
  logic [15:0]        cur_arg;
  logic [REM_W-1:0]   rem;
  logic               drop;

  logic               empty, full, push, pop;
  logic [1:0]         head_op;
  logic [15:0]        head_arg;
  logic [REM_W-1:0]   head_rem;
  logic [1:0]         beat_reg;
  logic [7:0]         beat_data;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  // A full FIFO still accepts a push in the cycle IDLE pops the head.
  assign cmd_ready = rdy_q && (!full || state == S_IDLE);
  assign push      = cmd_valid && cmd_ready && !abort;
  assign pop       = (state == S_IDLE) && !empty && !abort;
  assign busy      = !empty || (state != S_IDLE);
  assign head_op   = mem[rd_ptr][17:16];
  assign head_arg  = mem[rd_ptr][15:0];

  // Beat count for a freshly popped command; FILL count 0 means 256.
  always_comb begin
    head_rem = REM_W'(1);
    case (head_op)
      OP_SET_ADDR: head_rem = REM_W'(2);
      OP_FILL:     head_rem = {(head_arg[15:8] == 8'h00), head_arg[15:8]};
      default:     head_rem = REM_W'(1);
    endcase
  end

  // Register/data pair for the next beat of the current command.
  always_comb begin
    beat_reg  = REG_DATA;
    beat_data = cur_arg[7:0];
    case (cur_op)
      OP_SET_ADDR: begin
        beat_reg  = (rem == REM_W'(2)) ? REG_ADDR_LO : REG_ADDR_HI;
        beat_data = (rem == REM_W'(2)) ? cur_arg[7:0] : cur_arg[15:8];
      end
      OP_SET_ATTR: begin
        // Bits 7:6 forced low so the write can never decode as a mode write.
        beat_reg  = REG_ATTR;
        beat_data = {2'b00, cur_arg[3:2], 2'b00, cur_arg[1:0]};
      end
      default: begin
        beat_reg  = REG_DATA;
        beat_data = cur_arg[7:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_arg};
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

  // Beat sequencer; ISSUE with bus_req low is the one-cycle launch after a pop.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      bus_req     <= 1'b0;
      bus_reg     <= 2'd0;
      bus_data    <= 8'd0;
      shadow_addr <= 16'h0000;
      cur_op      <= 2'd0;
      cur_arg     <= 16'h0000;
      rem         <= '0;
      drop        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_op  <= head_op;
            cur_arg <= head_arg;
            rem     <= head_rem;
            drop    <= 1'b0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!bus_req) begin
            if (abort) begin
              state <= S_IDLE;
            end else begin
              bus_req  <= 1'b1;
              bus_reg  <= beat_reg;
              bus_data <= beat_data;
            end
          end else begin
            if (abort) drop <= 1'b1;
            if (bus_ack) begin
              bus_req <= 1'b0;
              rem     <= rem - REM_W'(1);
              state   <= S_GAP;
              if (cur_op == OP_SET_ADDR && rem == REM_W'(1))
                shadow_addr <= cur_arg;
              else if (cur_op == OP_PUT || cur_op == OP_FILL)
                shadow_addr <= shadow_addr + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (abort || drop || rem == '0) begin
            drop  <= 1'b0;
            state <= S_IDLE;
          end else begin
            bus_req  <= 1'b1;
            bus_reg  <= beat_reg;
            bus_data <= beat_data;
            state    <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_stream_writer.sv
// Directed bench for vram_stream_writer: command table plus hand-built
// sequences for FIFO back-pressure, abort and reset corners.
module tb_vram_stream_writer;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        abort;
  logic        bus_req;
  logic [1:0]  bus_reg;
  logic [7:0]  bus_data;
  logic        bus_ack;
  logic        busy;
  logic [15:0] shadow_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vram_stream_writer #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .bus_req(bus_req),
    .bus_reg(bus_reg), .bus_data(bus_data), .bus_ack(bus_ack), .busy(busy),
    .shadow_addr(shadow_addr)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] arg;
    int          n;
    logic [1:0]  r0;
    logic [7:0]  d0;
    logic [1:0]  r1;
    logic [7:0]  d1;
    logic [15:0] sh;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] arg);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) check("push_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (bus_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus_req !== 1'b1) check(nm, 32'(bus_req), 32'd1);
  endtask

  // Waits for a beat, checks it, holds ack low dly cycles, acks, checks the gap.
  task automatic expect_beat(input string nm, input logic [1:0] r, input logic [7:0] d,
                             input int dly);
    wait_req({nm, "_timeout"});
    check({nm, "_beat"}, 32'({bus_reg, bus_data}), 32'({r, d}));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check({nm, "_hold"}, 32'({bus_req, bus_reg, bus_data}), 32'({1'b1, r, d}));
    end
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check({nm, "_gap"}, 32'(bus_req), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] m_sh;

    vecs[0] = '{2'd1, 16'h000F, 1,   2'd3, 8'h33, 2'd3, 8'h33, 16'h2345};
    vecs[1] = '{2'd1, 16'h0006, 1,   2'd3, 8'h12, 2'd3, 8'h12, 16'h2345};
    vecs[2] = '{2'd1, 16'hFFF0, 1,   2'd3, 8'h00, 2'd3, 8'h00, 16'h2345};
    vecs[3] = '{2'd2, 16'hAB77, 1,   2'd2, 8'h77, 2'd2, 8'h77, 16'h2346};
    vecs[4] = '{2'd0, 16'hFFFE, 2,   2'd0, 8'hFE, 2'd1, 8'hFF, 16'hFFFE};
    vecs[5] = '{2'd3, 16'h03C7, 3,   2'd2, 8'hC7, 2'd2, 8'hC7, 16'h0001};
    vecs[6] = '{2'd3, 16'h0055, 256, 2'd2, 8'h55, 2'd2, 8'h55, 16'h0101};
    vecs[7] = '{2'd0, 16'h1200, 2,   2'd0, 8'h00, 2'd1, 8'h12, 16'h1200};
    vecs[8] = '{2'd3, 16'h0100, 1,   2'd2, 8'h00, 2'd2, 8'h00, 16'h1201};

    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = 16'h0000;
    abort     = 1'b0;
    bus_ack   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_regdata", 32'({bus_reg, bus_data}), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_shadow", 32'(shadow_addr), 32'h0000);
    sys_rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(cmd_ready), 32'd1);

    // SET_ADDR $2345: launch latency, stray ack ignored while bus_req is low
    push(2'd0, 16'h2345);
    check("lat_k", 32'({bus_req, busy}), 32'b01);
    bus_ack = 1'b1;
    @(negedge clk);
    check("lat_k1", 32'(bus_req), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    check("lat_k2", 32'({bus_req, bus_reg, bus_data}), 32'({1'b1, 2'd0, 8'h45}));
    expect_beat("addr_lo", 2'd0, 8'h45, 0);
    expect_beat("addr_hi", 2'd1, 8'h23, 0);
    check("addr_shadow", 32'(shadow_addr), 32'h2345);
    check("addr_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    check("addr_busy_fall", 32'(busy), 32'd0);

    // Command table
    m_sh = 16'h2345;
    for (int i = 0; i < 9; i++) begin
      push(vecs[i].op, vecs[i].arg);
      for (int b = 0; b < vecs[i].n; b++) begin
        if (b == 0) expect_beat($sformatf("vec%0d_b%0d", i, b), vecs[i].r0, vecs[i].d0, (i + b) % 3);
        else        expect_beat($sformatf("vec%0d_b%0d", i, b), vecs[i].r1, vecs[i].d1, (i + b) % 3);
        if (vecs[i].op == 2'd0 && b == 1) m_sh = vecs[i].arg;
        else if (vecs[i].op[1])           m_sh = m_sh + 16'd1;
        check($sformatf("vec%0d_sh%0d", i, b), 32'(shadow_addr), 32'(m_sh));
      end
      check($sformatf("vec%0d_final", i), 32'(shadow_addr), 32'(vecs[i].sh));
      @(negedge clk);
      check($sformatf("vec%0d_idle", i), 32'({busy, bus_req}), 32'd0);
    end

    // FIFO back-pressure with ack held low
    for (int i = 1; i <= 5; i++) push(2'd2, 16'(i));
    check("full_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_arg   = 16'h0006;
    @(negedge clk);
    check("full_hold", 32'(cmd_ready), 32'd0);
    expect_beat("fifo1", 2'd2, 8'h01, 0);
    check("full_gap_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("full_pop_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("full_again", 32'(cmd_ready), 32'd0);
    for (int i = 2; i <= 6; i++) expect_beat($sformatf("fifo%0d", i), 2'd2, 8'(i), 0);
    check("fifo_shadow", 32'(shadow_addr), 32'h1207);
    @(negedge clk);
    check("fifo_idle", 32'(busy), 32'd0);

    // Abort while bus_req is low (during GAP)
    push(2'd3, 16'h0511);
    expect_beat("agap", 2'd2, 8'h11, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("agap_idle", 32'({busy, bus_req}), 32'd0);
    repeat (3) @(negedge clk);
    check("agap_quiet", 32'(bus_req), 32'd0);
    check("agap_shadow", 32'(shadow_addr), 32'h1208);

    // Abort during beat 3 of FILL 10 with a slow ack; queued and same-cycle pushes dropped
    push(2'd3, 16'h0A33);
    push(2'd2, 16'h0099);
    expect_beat("ab1", 2'd2, 8'h33, 0);
    expect_beat("ab2", 2'd2, 8'h33, 0);
    wait_req("ab3_timeout");
    check("ab3_beat", 32'({bus_reg, bus_data}), 32'({2'd2, 8'h33}));
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_arg   = 16'h00EE;
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("ab3_hold0", 32'({bus_req, bus_reg, bus_data}), 32'({1'b1, 2'd2, 8'h33}));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("ab3_hold%0d", i), 32'({bus_req, bus_reg, bus_data}), 32'({1'b1, 2'd2, 8'h33}));
    end
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("ab3_gap", 32'(bus_req), 32'd0);
    check("ab3_shadow", 32'(shadow_addr), 32'h120B);
    @(negedge clk);
    check("ab_idle", 32'({busy, bus_req}), 32'd0);
    repeat (4) @(negedge clk);
    check("ab_no_beat4", 32'({busy, bus_req}), 32'd0);

    // Reset in the middle of a beat
    push(2'd2, 16'h0042);
    wait_req("rmid_timeout");
    sys_rst_n = 1'b0;
    #1;
    check("rmid_req", 32'(bus_req), 32'd0);
    check("rmid_shadow", 32'(shadow_addr), 32'h0000);
    check("rmid_ready_busy", 32'({cmd_ready, busy}), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
    check("rmid_release", 32'({cmd_ready, busy, bus_req}), 32'b100);
    repeat (3) @(negedge clk);
    check("rmid_quiet", 32'(bus_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
